// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: operand/handshake bus between the execute stage and the ALU.
interface alu_multicycle_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [4:0]       ctrl_ALUopcode;
  logic [SHW-1:0]   ctrl_shiftamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_result;
  logic             isNotEqual;
  logic             isLessThan;
  logic             overflow;
  logic             div_by_zero;
  logic             busy;

  // Producer/consumer side (execute stage)
  modport master (
    output in_valid, data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt, out_ready,
    input  in_ready, out_valid, data_result, isNotEqual, isLessThan, overflow, div_by_zero, busy
  );

  // ALU side
  modport slave (
    input  in_valid, data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt, out_ready,
    output in_ready, out_valid, data_result, isNotEqual, isLessThan, overflow, div_by_zero, busy
  );
endinterface

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered execute-stage ALU; single-cycle ops plus iterative signed
// MUL (shift-add) and DIV (restoring) over magnitudes, with a one-entry result buffer.
module alu_multicycle #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input logic             clock,
  input logic             reset,
  alu_multicycle_if.slave bus
);
  localparam int unsigned DW = 2 * WIDTH;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;
  localparam logic [4:0] OP_MUL = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;

  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHW-1:0]   LAST_ITER = SHW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  logic [SHW-1:0]   count;
  logic             is_div;
  logic             neg;
  logic             div_ovf;
  logic             pend_ne;
  logic             pend_lt;

  // MUL datapath: shifted multiplicand, accumulator; mplr doubles as DIV dividend/quotient
  logic [DW-1:0]    mcand;
  logic [DW-1:0]    acc;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;

  // Result buffer
  logic             valid_q;
  logic [WIDTH-1:0] result_q;
  logic             ne_q;
  logic             lt_q;
  logic             ovf_q;
  logic             dbz_q;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             ne_in;
  logic             lt_in;
  logic             in_ready;
  logic             accept;

  logic [WIDTH-1:0] sc_result;
  logic             sc_ovf;
  logic             sc_dbz;
  logic             start_mul;
  logic             start_div;

  logic [DW-1:0]    acc_step;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_trial;
  logic             quo_bit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [DW-1:0]    prod;
  logic [WIDTH:0]   prod_hi;
  logic             mul_ovf;
  logic [WIDTH-1:0] quo_signed;

  assign a        = bus.data_operandA;
  assign b        = bus.data_operandB;
  assign sum      = a + b;
  assign diff     = a - b;
  assign mag_a    = a[WIDTH-1] ? -a : a;
  assign mag_b    = b[WIDTH-1] ? -b : b;
  assign ne_in    = (a != b);
  assign lt_in    = ($signed(a) < $signed(b));
  assign in_ready = (state == IDLE) && (!valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = valid_q;
  assign bus.data_result = result_q;
  assign bus.isNotEqual  = ne_q;
  assign bus.isLessThan  = lt_q;
  assign bus.overflow    = ovf_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.busy        = (state == BUSY);

  // Opcode decode: single-cycle results and multi-cycle launch requests
  always_comb begin
    sc_result = '0;
    sc_ovf    = 1'b0;
    sc_dbz    = 1'b0;
    start_mul = 1'b0;
    start_div = 1'b0;
    case (bus.ctrl_ALUopcode)
      OP_ADD: begin
        sc_result = sum;
        sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result = diff;
        sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  sc_result = a & b;
      OP_OR:   sc_result = a | b;
      OP_SLL:  sc_result = a << bus.ctrl_shiftamt;
      OP_SRA:  sc_result = WIDTH'($signed(a) >>> bus.ctrl_shiftamt);
      OP_MUL:  start_mul = 1'b1;
      OP_DIV: begin
        if (b == '0) sc_dbz = 1'b1;
        else         start_div = 1'b1;
      end
      default: sc_result = '0;
    endcase
  end

  // One iteration step of each algorithm plus final sign correction
  always_comb begin
    acc_step   = mplr[0] ? (acc + mcand) : acc;
    rem_shift  = {rem, mplr[WIDTH-1]};
    rem_trial  = rem_shift - {1'b0, divisor};
    quo_bit    = ~rem_trial[WIDTH];
    rem_step   = quo_bit ? rem_trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_step   = {mplr[WIDTH-2:0], quo_bit};
    prod       = neg ? -acc_step : acc_step;
    prod_hi    = prod[DW-1:WIDTH-1];
    mul_ovf    = ~((&prod_hi) | ~(|prod_hi));
    quo_signed = neg ? -quo_step : quo_step;
  end

  // Control FSM, iteration datapath and result buffer
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      is_div   <= 1'b0;
      neg      <= 1'b0;
      div_ovf  <= 1'b0;
      pend_ne  <= 1'b0;
      pend_lt  <= 1'b0;
      mcand    <= '0;
      acc      <= '0;
      mplr     <= '0;
      divisor  <= '0;
      rem      <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      ne_q     <= 1'b0;
      lt_q     <= 1'b0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      // Consumer drains the buffer; a same-edge load below takes priority
      if (bus.out_ready) valid_q <= 1'b0;

      if (state == IDLE) begin
        if (accept) begin
          pend_ne <= ne_in;
          pend_lt <= lt_in;
          neg     <= a[WIDTH-1] ^ b[WIDTH-1];
          is_div  <= start_div;
          div_ovf <= (a == MOST_NEG) && (b == '1);
          count   <= '0;
          if (start_mul) begin
            state <= BUSY;
            mcand <= DW'(mag_a);
            acc   <= '0;
            mplr  <= mag_b;
          end else if (start_div) begin
            state   <= BUSY;
            mplr    <= mag_a;
            divisor <= mag_b;
            rem     <= '0;
          end else begin
            valid_q  <= 1'b1;
            result_q <= sc_result;
            ne_q     <= ne_in;
            lt_q     <= lt_in;
            ovf_q    <= sc_ovf;
            dbz_q    <= sc_dbz;
          end
        end
      end else begin
        count <= count + SHW'(1);
        if (is_div) begin
          mplr <= quo_step;
          rem  <= rem_step;
        end else begin
          acc   <= acc_step;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
        end
        // Last iteration folds into the buffer load; in_ready guaranteed the buffer is free
        if (count == LAST_ITER) begin
          state    <= IDLE;
          valid_q  <= 1'b1;
          result_q <= is_div ? quo_signed : prod[WIDTH-1:0];
          ne_q     <= pend_ne;
          lt_q     <= pend_lt;
          ovf_q    <= is_div ? div_ovf : mul_ovf;
          dbz_q    <= 1'b0;
        end
      end
    end
  end
endmodule
